pipelined_mul_unit: RTL

- Parametrised, fully pipelined successor to the single-issue Booth multiplier FU.
- Accepts one multiply per cycle from the reservation-station issue logic and supports all four RV32M multiply flavours (MUL, MULH, MULHSU, MULHU).
- Buffers completed results in an in-order result FIFO until the CDB arbiter grants them, with credit-based back-pressure so the pipeline never stalls internally.
- Supports a misprediction flush.

---
 rtl/pipelined_mul_unit.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pipelined_mul_unit.sv
// Fully pipelined RV32M multiply unit (MUL/MULH/MULHSU/MULHU) with an in-order result FIFO
// and credit-based issue back-pressure. Define MUL_UNIT_PERF_CNT_EN to add performance counters.
module pipelined_mul_unit #(
  parameter int DATA_W       = 32,
  parameter int TAG_W        = 4,
  parameter int ROB_W        = 4,
  parameter int STAGES       = 3,
  parameter int RESULT_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic [1:0]        issue_op_i,
  input  logic [DATA_W-1:0] issue_a_i,
  input  logic [DATA_W-1:0] issue_b_i,
  input  logic [TAG_W-1:0]  issue_tag_i,
  input  logic [ROB_W-1:0]  issue_rob_i,
  input  logic              flush_i,
  input  logic              cdb_grant_i,
  output logic              result_valid_o,
  output logic [DATA_W-1:0] result_data_o,
  output logic [TAG_W-1:0]  result_tag_o,
  output logic [ROB_W-1:0]  result_rob_o,
  output logic              busy_o
`ifdef MUL_UNIT_PERF_CNT_EN
  ,
  output logic [31:0]       perf_issued_o,
  output logic [31:0]       perf_stall_o
`endif
);

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_e;

  localparam int PW    = 2 * DATA_W;
  localparam int PTR_W = (RESULT_DEPTH > 1) ? $clog2(RESULT_DEPTH) : 1;
  localparam int OCC_W = $clog2(RESULT_DEPTH + 1);
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(RESULT_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RESULT_DEPTH - 1);

  logic              issue_fire;
  logic              pop;
  logic              fifo_wr;
  logic [OCC_W-1:0]  occ;
  logic [OCC_W-1:0]  fifo_cnt;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  logic [DATA_W-1:0] fifo_data [RESULT_DEPTH];
  logic [TAG_W-1:0]  fifo_tag  [RESULT_DEPTH];
  logic [ROB_W-1:0]  fifo_rob  [RESULT_DEPTH];

  logic [STAGES-1:0] s_valid;
  logic [1:0]        s_op   [STAGES];
  logic [TAG_W-1:0]  s_tag  [STAGES];
  logic [ROB_W-1:0]  s_rob  [STAGES];
  logic [PW-1:0]     s_prod [STAGES];

  logic              a_sign;
  logic              b_sign;
  logic [PW-1:0]     a_ext;
  logic [PW-1:0]     b_ext;
  logic [PW-1:0]     prod;
  logic [DATA_W-1:0] tail_data;

  // Credits cover both in-flight ops and buffered results, so the FIFO can never overflow.
  assign issue_ready_o  = reset_n_i && (occ < DEPTH_C) && !flush_i;
  assign issue_fire     = issue_valid_i && issue_ready_o;
  assign result_valid_o = (fifo_cnt != '0);
  assign pop            = cdb_grant_i && result_valid_o && !flush_i;
  assign fifo_wr        = s_valid[STAGES-1] && !flush_i;
  assign busy_o         = (occ != '0);

  // Sign-extending to 2*DATA_W makes the truncated unsigned product bit-exact for every flavour.
  always_comb begin
    a_sign = 1'b0;
    b_sign = 1'b0;
    if ((issue_op_i == OP_MULH) || (issue_op_i == OP_MULHSU)) begin
      a_sign = issue_a_i[DATA_W-1];
    end
    if (issue_op_i == OP_MULH) begin
      b_sign = issue_b_i[DATA_W-1];
    end
    a_ext = {{DATA_W{a_sign}}, issue_a_i};
    b_ext = {{DATA_W{b_sign}}, issue_b_i};
    prod  = a_ext * b_ext;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s_valid <= '0;
      for (int i = 0; i < STAGES; i++) begin
        s_op[i]   <= '0;
        s_tag[i]  <= '0;
        s_rob[i]  <= '0;
        s_prod[i] <= '0;
      end
    end else begin
      s_valid[0] <= issue_fire;
      s_op[0]    <= issue_op_i;
      s_tag[0]   <= issue_tag_i;
      s_rob[0]   <= issue_rob_i;
      s_prod[0]  <= prod;
      for (int i = 1; i < STAGES; i++) begin
        s_valid[i] <= s_valid[i-1] && !flush_i;
        s_op[i]    <= s_op[i-1];
        s_tag[i]   <= s_tag[i-1];
        s_rob[i]   <= s_rob[i-1];
        s_prod[i]  <= s_prod[i-1];
      end
    end
  end

  assign tail_data = (s_op[STAGES-1] == OP_MUL) ? s_prod[STAGES-1][DATA_W-1:0]
                                                 : s_prod[STAGES-1][PW-1:DATA_W];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < RESULT_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_tag[i]  <= '0;
        fifo_rob[i]  <= '0;
      end
    end else if (flush_i) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_wr) begin
        fifo_data[wr_ptr] <= tail_data;
        fifo_tag[wr_ptr]  <= s_tag[STAGES-1];
        fifo_rob[wr_ptr]  <= s_rob[STAGES-1];
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({fifo_wr, pop})
        2'b10:   fifo_cnt <= fifo_cnt + OCC_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - OCC_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      occ <= '0;
    end else if (flush_i) begin
      occ <= '0;
    end else begin
      case ({issue_fire, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign result_data_o = result_valid_o ? fifo_data[rd_ptr] : '0;
  assign result_tag_o  = result_valid_o ? fifo_tag[rd_ptr]  : '0;
  assign result_rob_o  = result_valid_o ? fifo_rob[rd_ptr]  : '0;

`ifdef MUL_UNIT_PERF_CNT_EN
  // Counters survive a flush; only reset clears them. Both saturate.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      perf_issued_o <= '0;
      perf_stall_o  <= '0;
    end else begin
      if (issue_fire && (perf_issued_o != 32'hFFFF_FFFF)) begin
        perf_issued_o <= perf_issued_o + 32'd1;
      end
      if (result_valid_o && !cdb_grant_i && (perf_stall_o != 32'hFFFF_FFFF)) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end
    end
  end
`endif

endmodule
